// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between WB and a FIFO of LU results; tracks pending LU writes.
// Optional same-cycle LU bypass into the rf outputs when idle: define ARB_LU_BYPASS_EN.
module regfile_write_arbiter #(
   parameter int QDEPTH       = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        r,
   input  logic        wb_valid,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        wb_stall,
   input  logic        lu_valid,
   output logic        lu_ready,
   input  logic [4:0]  lu_addr,
   input  logic [31:0] lu_data,
   input  logic        sb_set,
   input  logic [4:0]  sb_addr,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        rs1_busy,
   output logic        rs2_busy,
   output logic        rf_write_enable,
   output logic [4:0]  rf_write_addr,
   output logic [31:0] rf_write_data
);

   localparam int AW = $clog2(QDEPTH);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

   logic [4:0]    q_addr [QDEPTH];
   logic [31:0]   q_data [QDEPTH];
   logic [AW:0]   wptr, rptr;
   logic [CW-1:0] starve_cnt;
   logic [31:0]   pending, pending_nxt;

   logic          empty, full, starve, wb_win, pop, push, bypass;
   logic [4:0]    head_addr;
   logic [31:0]   head_data;

   assign empty     = (wptr == rptr);
   assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign head_addr = q_addr[rptr[AW-1:0]];
   assign head_data = q_data[rptr[AW-1:0]];

   assign starve   = !empty && (starve_cnt == CNT_MAX);
   assign wb_stall = starve;
   assign lu_ready = !full;
   assign wb_win   = wb_valid && !starve;
   assign pop      = !empty && !wb_win;

`ifdef ARB_LU_BYPASS_EN
   assign bypass = empty && !wb_valid && !starve && lu_valid && (lu_addr != 5'd0);
`else
   assign bypass = 1'b0;
`endif

   // x0 results are acknowledged but never queued
   assign push = lu_valid && lu_ready && (lu_addr != 5'd0) && !bypass;

   assign rs1_busy = pending[rs1];
   assign rs2_busy = pending[rs2];

   // clears first, so a same-edge set on the same register wins
   always_comb begin
      pending_nxt = pending;
      if (pop)
         pending_nxt[head_addr] = 1'b0;
      if (bypass)
         pending_nxt[lu_addr] = 1'b0;
      if (sb_set && (sb_addr != 5'd0))
         pending_nxt[sb_addr] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wptr[AW-1:0]] <= lu_addr;
         q_data[wptr[AW-1:0]] <= lu_data;
      end
   end

   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         wptr            <= '0;
         rptr            <= '0;
         starve_cnt      <= '0;
         pending         <= '0;
         rf_write_enable <= 1'b0;
         rf_write_addr   <= 5'd0;
         rf_write_data   <= 32'd0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;

         if (pop || empty)
            starve_cnt <= '0;
         else if (wb_win && (starve_cnt != CNT_MAX))
            starve_cnt <= starve_cnt + CW'(1);

         pending <= pending_nxt;

         if (wb_win) begin
            rf_write_enable <= (wb_addr != 5'd0);
            rf_write_addr   <= wb_addr;
            rf_write_data   <= wb_data;
         end else if (pop) begin
            rf_write_enable <= 1'b1;
            rf_write_addr   <= head_addr;
            rf_write_data   <= head_data;
         end else if (bypass) begin
            rf_write_enable <= 1'b1;
            rf_write_addr   <= lu_addr;
            rf_write_data   <= lu_data;
         end else begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= 5'd0;
            rf_write_data   <= 32'd0;
         end
      end
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback stage (WB) and a long-latency unit (LU: loads, mul/div) in the rv32i pipelined core.
- Buffers LU results in a small FIFO and drives registered write-enable, address and data to the register file.
- Keeps a pending-write scoreboard so hazard logic can stall readers of registers still awaiting an LU result.

Parameters:
- QDEPTH, 2, LU result FIFO depth; power of two, minimum 2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO head may lose to WB before WB is stalled; minimum 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- r  in  1  reset, asynchronous, active-high.
- wb_valid  in  1  WB stage has a result.
- wb_addr  in  5  WB destination register.
- wb_data  in  32  WB result.
- wb_stall  out  1  combinational; WB not accepted this cycle, pipeline holds WB inputs stable.
- lu_valid  in  1  LU result offered.
- lu_ready  out  1  combinational; equals !full.
- lu_addr  in  5  LU destination register.
- lu_data  in  32  LU result.
- sb_set  in  1  LU op issued; mark sb_addr pending.
- sb_addr  in  5  register to mark pending.
- rs1  in  5  read address 1 for scoreboard query.
- rs2  in  5  read address 2 for scoreboard query.
- rs1_busy  out  1  combinational; pending[rs1].
- rs2_busy  out  1  combinational; pending[rs2].
- rf_write_enable  out  1  registered; to the register file.
- rf_write_addr  out  5  registered.
- rf_write_data  out  32  registered.

Behaviour:
- Reset (r high, asynchronous):
  - FIFO empty; pending = 0; starvation counter = 0.
  - rf_write_enable = 0, rf_write_addr = 0, rf_write_data = 0.
  - wb_stall = 0, lu_ready = 1.
  - Queued entries are discarded when reset is asserted mid-operation.
- Outputs rf_write_enable, rf_write_addr and rf_write_data are registered every cycle.
  - They are loaded with the winning source, or with write_enable = 0 if no source wins.
  - A winner at edge N is written into the register file at edge N+1.
- Arbitration at each posedge:
  - Starve mode is active when the FIFO is non-empty and the counter equals STARVE_LIMIT.
  - Starve mode: the FIFO head wins and wb_stall = 1, so WB is not accepted.
  - Otherwise: WB wins if wb_valid; else the FIFO head wins if the FIFO is non-empty; else idle.
- Starvation counter:
  - Increments when the FIFO is non-empty and WB wins.
  - Clears on every FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Handshakes:
  - LU handshake: accepted when lu_valid and lu_ready.
  - No push-through when full: lu_ready is derived from the current occupancy only.
  - A push and a pop in the same cycle are allowed when not full; occupancy is unchanged.
  - Without the bypass, an LU result accepted at edge N reaches the rf outputs at edge N+1 at the earliest and is written at edge N+2.
- x0 handling:
  - An accepted write to address 0 from either source is discarded.
  - WB to x0 counts as a win but produces write_enable = 0.
  - LU to x0 is acknowledged but not enqueued.
- FIFO: read and write pointers of log2(QDEPTH)+1 bits with wrap-around; full and empty come from pointer compare.
- Scoreboard:
  - sb_set with sb_addr != 0 sets pending[sb_addr].
  - A FIFO pop clears pending[head addr].
  - If set and clear hit the same address on the same edge, set wins.
  - WB writes never touch pending.
  - pending[0] is always 0.

Optional Feature:
- Macro ARB_LU_BYPASS_EN.
- Defined:
  - Condition: FIFO empty, wb_valid = 0, not in starve mode, lu_valid = 1 and lu_addr != 0.
  - The LU result loads the rf outputs directly at that edge and is not enqueued.
  - pending[lu_addr] is cleared on that edge; set still wins on collision.
  - Latency is 1 edge.
- Undefined: every LU result passes through the FIFO.

Test Plan:
- Reset mid-queue: push 2 LU results (x5 = 0xAA, x6 = 0xBB), assert r one cycle -> no rf writes follow, lu_ready = 1, pending = 0.
- Priority: wb_valid with x3 = 0x11 and lu_valid with x4 = 0x22 on the same edge -> rf writes x3 first, then x4 on the next edge.
- Full FIFO: QDEPTH = 2, continuous wb_valid, 3 LU offers -> lu_ready = 0 after 2 accepts; the third is accepted only after a pop.
- Starvation: STARVE_LIMIT = 4, continuous wb_valid, 1 queued LU entry -> WB wins 4 edges, then wb_stall = 1 for one cycle, LU entry written, WB resumes.
- Scoreboard: sb_set x7; rs1 = 7 -> rs1_busy = 1 until the x7 LU write pops. sb_set x7 on the same edge as an x7 pop -> pending[7] stays 1.
- x0 and bypass:
  - wb_valid to x0 with data 0xFF -> rf_write_enable = 0.
  - With ARB_LU_BYPASS_EN and an idle arbiter, LU x9 = 0x33 appears on the rf outputs 1 edge after acceptance.
